// File: rtl/pipeline_hazard_ctrl_if.sv
// rtl/pipeline_hazard_ctrl_if.sv - pipeline-to-hazard-controller signal bundle
// master = datapath side, slave = hazard controller side.
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       rsD, rtD, rsE, rtE;
  logic [4:0]       rtdE, rtdM, rtdW;
  logic             RFWEE, RFWEM, RFWEW;
  logic             MtoRFSelE, MtoRFSelM;
  logic             DMWEM;
  logic             BranchM, zeroM;
  logic             dm_ready;
  logic             StallF, StallD, StallE, StallM;
  logic             FlushD, FlushE, FlushM, FlushW;
  logic             PCSrcM;
  logic [1:0]       ForwardAE, ForwardBE;
  logic             dm_req;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  modport master (
    output rsD, rtD, rsE, rtE, rtdE, rtdM, rtdW,
    output RFWEE, RFWEM, RFWEW, MtoRFSelE, MtoRFSelM, DMWEM,
    output BranchM, zeroM, dm_ready,
    input  StallF, StallD, StallE, StallM,
    input  FlushD, FlushE, FlushM, FlushW,
    input  PCSrcM, ForwardAE, ForwardBE, dm_req, mem_err, stall_cnt, flush_cnt
  );

  modport slave (
    input  rsD, rtD, rsE, rtE, rtdE, rtdM, rtdW,
    input  RFWEE, RFWEM, RFWEW, MtoRFSelE, MtoRFSelM, DMWEM,
    input  BranchM, zeroM, dm_ready,
    output StallF, StallD, StallE, StallM,
    output FlushD, FlushE, FlushM, FlushW,
    output PCSrcM, ForwardAE, ForwardBE, dm_req, mem_err, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush/forward control and data-memory wait FSM
// for the 5-stage pipeline, with saturating stall/flush event counters.
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  pipeline_hazard_ctrl_if.slave  hz
);

  localparam int WCW = $clog2(MEM_TIMEOUT);
  localparam logic [WCW-1:0] TO_LAST = WCW'(MEM_TIMEOUT - 1);

  typedef enum logic {S_RUN, S_WAIT} state_t;

  state_t           r_state, w_next_state;
  logic [WCW-1:0]   r_wait_cnt;
  logic             r_mem_err;
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

  logic w_memop, w_force_rel, w_memstall, w_pcsrc, w_lu, w_stall_f;
  logic [1:0] w_fwd_a, w_fwd_b;

  function automatic logic [1:0] fwd_sel(input logic [4:0] src);
    if (hz.RFWEM && (hz.rtdM != 5'd0) && (hz.rtdM == src))      return 2'b10;
    else if (hz.RFWEW && (hz.rtdW != 5'd0) && (hz.rtdW == src)) return 2'b01;
    else                                                         return 2'b00;
  endfunction

  always_comb begin
    w_memop     = hz.MtoRFSelM | hz.DMWEM;
    w_force_rel = (r_state == S_WAIT) && (r_wait_cnt == TO_LAST);
    w_memstall  = w_memop & ~hz.dm_ready & ~w_force_rel;
    w_pcsrc     = hz.BranchM & hz.zeroM;
    w_lu        = hz.MtoRFSelE & hz.RFWEE & (hz.rtdE != 5'd0) &
                  ((hz.rtdE == hz.rsD) | (hz.rtdE == hz.rtD));
    // A taken branch squashes the instruction that caused the load-use stall.
    w_stall_f   = w_memstall | (w_lu & ~w_pcsrc);
    w_fwd_a     = fwd_sel(hz.rsE);
    w_fwd_b     = fwd_sel(hz.rtE);
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_RUN:   if (w_memop && !hz.dm_ready) w_next_state = S_WAIT;
      S_WAIT:  if (hz.dm_ready || w_force_rel) w_next_state = S_RUN;
      default: w_next_state = S_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_RUN;
      r_wait_cnt  <= '0;
      r_mem_err   <= 1'b0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == S_WAIT && w_next_state == S_WAIT) r_wait_cnt <= r_wait_cnt + WCW'(1);
      else                                              r_wait_cnt <= '0;
      if (w_force_rel) r_mem_err <= 1'b1;
      if (w_stall_f && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_pcsrc && (r_flush_cnt != '1))   r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  // Combinational outputs are gated so they read zero throughout reset.
  assign hz.StallF    = rst_n & w_stall_f;
  assign hz.StallD    = rst_n & w_stall_f;
  assign hz.StallE    = rst_n & w_memstall;
  assign hz.StallM    = rst_n & w_memstall;
  assign hz.FlushD    = rst_n & w_pcsrc & ~w_memstall;
  assign hz.FlushE    = rst_n & ~w_memstall & (w_pcsrc | w_lu);
  assign hz.FlushM    = rst_n & w_pcsrc & ~w_memstall;
  assign hz.FlushW    = rst_n & w_memstall;
  assign hz.PCSrcM    = rst_n & w_pcsrc;
  assign hz.ForwardAE = rst_n ? w_fwd_a : 2'b00;
  assign hz.ForwardBE = rst_n ? w_fwd_b : 2'b00;
  assign hz.dm_req    = rst_n & w_memop;
  assign hz.mem_err   = r_mem_err;
  assign hz.stall_cnt = r_stall_cnt;
  assign hz.flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed and randomized checks of pipeline_hazard_ctrl
// against a cycle-level behavioural model of the hazard rules.
module tb_pipeline_hazard_ctrl;
  localparam int MEM_TIMEOUT = 4;
  localparam int CNT_W       = 6;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) hz();

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .hz   (hz)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    hz.rsD = 0; hz.rtD = 0; hz.rsE = 0; hz.rtE = 0;
    hz.rtdE = 0; hz.rtdM = 0; hz.rtdW = 0;
    hz.RFWEE = 0; hz.RFWEM = 0; hz.RFWEW = 0;
    hz.MtoRFSelE = 0; hz.MtoRFSelM = 0; hz.DMWEM = 0;
    hz.BranchM = 0; hz.zeroM = 0; hz.dm_ready = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: m_wait_age < 0 means no memory wait in progress.
  int m_wait_age = -1;
  bit m_err = 0;
  int m_sc = 0, m_fc = 0;

  function automatic int fwd_exp(input logic [4:0] src);
    if (hz.RFWEM && hz.rtdM != 0 && hz.rtdM == src) return 2;
    if (hz.RFWEW && hz.rtdW != 0 && hz.rtdW == src) return 1;
    return 0;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      m_wait_age = -1; m_err = 0; m_sc = 0; m_fc = 0;
      chk("rst_StallF", hz.StallF, 0);  chk("rst_StallM", hz.StallM, 0);
      chk("rst_FlushE", hz.FlushE, 0);  chk("rst_FlushW", hz.FlushW, 0);
      chk("rst_PCSrcM", hz.PCSrcM, 0);  chk("rst_dm_req", hz.dm_req, 0);
      chk("rst_FwdA", hz.ForwardAE, 0); chk("rst_FwdB", hz.ForwardBE, 0);
      chk("rst_mem_err", hz.mem_err, 0);
      chk("rst_stall_cnt", hz.stall_cnt, 0); chk("rst_flush_cnt", hz.flush_cnt, 0);
    end else begin
      bit memop, timeout, ms, br, lu, sf;
      memop   = hz.MtoRFSelM || hz.DMWEM;
      timeout = (m_wait_age == MEM_TIMEOUT - 1);
      ms      = memop && !hz.dm_ready && !timeout;
      br      = hz.BranchM && hz.zeroM;
      lu      = hz.MtoRFSelE && hz.RFWEE && hz.rtdE != 0 &&
                (hz.rtdE == hz.rsD || hz.rtdE == hz.rtD);
      sf      = ms || (lu && !br);
      chk("StallF", hz.StallF, int'(sf));
      chk("StallD", hz.StallD, int'(sf));
      chk("StallE", hz.StallE, int'(ms));
      chk("StallM", hz.StallM, int'(ms));
      chk("FlushD", hz.FlushD, int'(br && !ms));
      chk("FlushE", hz.FlushE, int'(!ms && (br || lu)));
      chk("FlushM", hz.FlushM, int'(br && !ms));
      chk("FlushW", hz.FlushW, int'(ms));
      chk("PCSrcM", hz.PCSrcM, int'(br));
      chk("ForwardAE", hz.ForwardAE, fwd_exp(hz.rsE));
      chk("ForwardBE", hz.ForwardBE, fwd_exp(hz.rtE));
      chk("dm_req", hz.dm_req, int'(memop));
      chk("mem_err", hz.mem_err, int'(m_err));
      chk("stall_cnt", hz.stall_cnt, m_sc);
      chk("flush_cnt", hz.flush_cnt, m_fc);
      if (m_wait_age < 0) begin
        if (memop && !hz.dm_ready) m_wait_age = 0;
      end else if (hz.dm_ready || timeout) m_wait_age = -1;
      else m_wait_age++;
      if (timeout) m_err = 1;
      if (sf && m_sc < CNT_MAX) m_sc++;
      if (br && m_fc < CNT_MAX) m_fc++;
    end
  end

  initial begin
    clear_inputs();
    repeat (3) @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;

    // Load-use hazard followed by MEM->EX forward of the load.
    hz.MtoRFSelE = 1; hz.RFWEE = 1; hz.rtdE = 2; hz.rsD = 2;
    @(negedge clk);
    chk("lu_StallF", hz.StallF, 1); chk("lu_StallD", hz.StallD, 1); chk("lu_FlushE", hz.FlushE, 1);
    next_cycle(); clear_inputs();
    hz.MtoRFSelM = 1; hz.RFWEM = 1; hz.rtdM = 2; hz.rsE = 2; hz.dm_ready = 1;
    @(negedge clk);
    chk("lu_fwdA", hz.ForwardAE, 2); chk("lu_stall_cnt", hz.stall_cnt, 1); chk("lu_released", hz.StallF, 0);

    next_cycle(); clear_inputs();
    hz.rtdM = 5; hz.RFWEM = 1; hz.rtdW = 5; hz.RFWEW = 1; hz.rsE = 5; hz.rtE = 0;
    @(negedge clk);
    chk("fwd_mem_A", hz.ForwardAE, 2); chk("fwd_r0_B", hz.ForwardBE, 0);
    next_cycle(); hz.rtdM = 0;
    @(negedge clk);
    chk("fwd_wb_A", hz.ForwardAE, 1);

    // Taken branch overrides a concurrent load-use stall.
    next_cycle(); clear_inputs();
    hz.BranchM = 1; hz.zeroM = 1; hz.MtoRFSelE = 1; hz.RFWEE = 1; hz.rtdE = 3; hz.rtD = 3;
    @(negedge clk);
    chk("br_PCSrcM", hz.PCSrcM, 1); chk("br_FlushD", hz.FlushD, 1); chk("br_FlushE", hz.FlushE, 1);
    chk("br_FlushM", hz.FlushM, 1); chk("br_StallF", hz.StallF, 0); chk("br_StallD", hz.StallD, 0);
    next_cycle(); clear_inputs();
    @(negedge clk);
    chk("br_flush_cnt", hz.flush_cnt, 1); chk("br_stall_cnt", hz.stall_cnt, 1);

    // Store waiting three cycles on memory.
    next_cycle(); hz.DMWEM = 1; hz.dm_ready = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("st_StallF", hz.StallF, 1); chk("st_StallE", hz.StallE, 1);
      chk("st_StallM", hz.StallM, 1); chk("st_FlushW", hz.FlushW, 1);
      if (i < 2) next_cycle();
    end
    next_cycle(); hz.dm_ready = 1;
    @(negedge clk);
    chk("st_rel_StallF", hz.StallF, 0); chk("st_rel_FlushW", hz.FlushW, 0); chk("st_mem_err", hz.mem_err, 0);
    next_cycle(); clear_inputs();
    @(negedge clk);
    chk("st_stall_cnt", hz.stall_cnt, 4);

    // Load never acknowledged: forced release after MEM_TIMEOUT stall cycles.
    next_cycle(); hz.MtoRFSelM = 1; hz.dm_ready = 0;
    for (int i = 0; i < MEM_TIMEOUT; i++) begin
      @(negedge clk);
      chk("to_StallF", hz.StallF, 1);
      next_cycle();
    end
    @(negedge clk);
    chk("to_release", hz.StallF, 0); chk("to_err_pending", hz.mem_err, 0);
    next_cycle(); clear_inputs();
    @(negedge clk);
    chk("to_mem_err", hz.mem_err, 1); chk("to_stall_cnt", hz.stall_cnt, 8);
    next_cycle(); hz.MtoRFSelM = 1; hz.dm_ready = 0;
    @(negedge clk);
    chk("to_back_in_run", hz.StallF, 1);
    next_cycle(); hz.dm_ready = 1;
    @(negedge clk);
    chk("to_ack", hz.StallF, 0);

    // Asynchronous reset in the middle of a wait.
    next_cycle(); hz.dm_ready = 0;
    next_cycle();
    #2 rst_n = 1'b0;
    #1;
    chk("ar_StallF", hz.StallF, 0); chk("ar_FlushW", hz.FlushW, 0); chk("ar_dm_req", hz.dm_req, 0);
    chk("ar_mem_err", hz.mem_err, 0); chk("ar_stall_cnt", hz.stall_cnt, 0);
    @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("ar_post_stall", hz.StallF, 1); chk("ar_post_cnt", hz.stall_cnt, 0);
    next_cycle(); clear_inputs();

    for (int c = 0; c < 600; c++) begin
      next_cycle();
      hz.rsD = 5'($urandom_range(0, 3)); hz.rtD = 5'($urandom_range(0, 3));
      hz.rsE = 5'($urandom_range(0, 3)); hz.rtE = 5'($urandom_range(0, 3));
      hz.rtdE = 5'($urandom_range(0, 3)); hz.rtdM = 5'($urandom_range(0, 3));
      hz.rtdW = 5'($urandom_range(0, 3));
      hz.RFWEE = 1'($urandom); hz.RFWEM = 1'($urandom); hz.RFWEW = 1'($urandom);
      hz.MtoRFSelE = 1'($urandom);
      hz.MtoRFSelM = ($urandom % 4 == 0);
      hz.DMWEM = ($urandom % 5 == 0);
      hz.BranchM = (hz.MtoRFSelM || hz.DMWEM) ? 1'b0 : ($urandom % 4 == 0);
      hz.zeroM = 1'($urandom);
      hz.dm_ready = ($urandom % 3 != 0);
    end
    next_cycle(); clear_inputs();
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
